mcyc_mem_responder: RTL

- Unified instruction/data memory for the multicycle ARM core. It is the responder on the controller's memory-request interface: the controller drives address, write enable and write data; this block answers after a fixed wait-state latency.
- It replaces the zero-latency memory so that the control FSM can be run against a slave that stalls with real wait states.
- It sits between the datapath address/write-data mux and the instruction/data registers.

---
 rtl/mcyc_mem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mcyc_mem_responder.sv
// Unified instruction/data memory answering the multicycle core after LATENCY wait cycles.
// Optional macro MCYC_MEM_ERR_EN adds an err output for misaligned or out-of-range addresses.
module mcyc_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef MCYC_MEM_ERR_EN
    output logic        err,
`endif
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic          done_nxt_s;
    logic          we_r;
    logic [31:0]   wdata_r;
    logic [AW-1:0] idx_r;
    logic          cur_we_s;
    logic [31:0]   cur_wdata_s;
    logic [AW-1:0] cur_idx_s;
    logic          cur_err_s;
    logic [31:0]   mem_r [DEPTH];

`ifdef MCYC_MEM_ERR_EN
    logic err_r;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != {(30-AW){1'b0}});
    endfunction
`else
    logic unused_s;
    assign unused_s = ^{adr[31:AW+2], adr[1:0]};
`endif

    // Next-state and wait counter; done_nxt_s marks the edge that enters DONE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    cnt_nxt_s = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accept edge, so IDLE uses live inputs.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = we;
            cur_wdata_s = wdata;
            cur_idx_s   = adr[AW+1:2];
`ifdef MCYC_MEM_ERR_EN
            cur_err_s   = addr_err(adr);
`else
            cur_err_s   = 1'b0;
`endif
        end else begin
            cur_we_s    = we_r;
            cur_wdata_s = wdata_r;
            cur_idx_s   = idx_r;
`ifdef MCYC_MEM_ERR_EN
            cur_err_s   = err_r;
`else
            cur_err_s   = 1'b0;
`endif
        end
    end

    // Control state, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            wdata_r <= 32'h0;
            idx_r   <= {AW{1'b0}};
            ready   <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'h0;
`ifdef MCYC_MEM_ERR_EN
            err_r   <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready   <= done_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_IDLE && req) begin
                we_r    <= we;
                wdata_r <= wdata;
                idx_r   <= adr[AW+1:2];
`ifdef MCYC_MEM_ERR_EN
                err_r   <= addr_err(adr);
`endif
            end
            if (done_nxt_s && !cur_we_s && !cur_err_s) begin
                rdata <= mem_r[cur_idx_s];
            end
`ifdef MCYC_MEM_ERR_EN
            err <= done_nxt_s && cur_err_s;
`endif
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && done_nxt_s && cur_we_s && !cur_err_s) begin
            mem_r[cur_idx_s] <= cur_wdata_s;
        end
    end

endmodule
